// File: rtl/psum_acc_if.sv
// rtl/psum_acc_if.sv - psum input beats, result handshake and status between the pe and writeback
interface psum_acc_if #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 32
);
  logic [2*BIT_WIDTH-1:0] i_psum;
  logic                   i_psum_vld;
  logic                   i_clr;
  logic [ACC_WIDTH-1:0]   o_acc;
  logic                   o_acc_sat;
  logic                   o_acc_vld;
  logic                   i_acc_rdy;
  logic                   o_busy;
  logic                   o_ovr_err;
  logic                   i_err_clr;

  modport master (
    output i_psum, i_psum_vld, i_clr, i_acc_rdy, i_err_clr,
    input  o_acc, o_acc_sat, o_acc_vld, o_busy, o_ovr_err
  );

  modport slave (
    input  i_psum, i_psum_vld, i_clr, i_acc_rdy, i_err_clr,
    output o_acc, o_acc_sat, o_acc_vld, o_busy, o_ovr_err
  );
endinterface

// File: rtl/psum_acc.sv
// rtl/psum_acc.sv - saturating ACC_LEN-beat partial-sum accumulator with a 2-entry show-ahead result FIFO
module psum_acc #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int ACC_LEN   = 9
) (
  input  logic     clk,
  input  logic     rst,
  psum_acc_if.slave bus
);
  localparam int SW    = ACC_WIDTH + 1;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  logic [CNT_W-1:0]     cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 sat;

  logic [ACC_WIDTH-1:0] mem_acc [2];
  logic                 mem_sat [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;
  logic                 ovr_err;

  logic                 beat;
  logic                 first;
  logic                 last;
  logic [ACC_WIDTH-1:0] base;
  logic [SW-1:0]        sum_w;
  logic                 carry;
  logic [ACC_WIDTH-1:0] nxt_acc;
  logic                 nxt_sat;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 do_push;
  logic                 overrun;

  // The first beat of a result starts from zero, so the old acc never leaks in.
  always_comb begin
    beat    = bus.i_psum_vld & ~bus.i_clr;
    first   = (cnt == '0);
    last    = (cnt == CNT_W'(ACC_LEN - 1));
    base    = first ? '0 : acc;
    sum_w   = {1'b0, base} + SW'(bus.i_psum);
    carry   = sum_w[ACC_WIDTH];
    nxt_acc = carry ? {ACC_WIDTH{1'b1}} : sum_w[ACC_WIDTH-1:0];
    nxt_sat = carry | (sat & ~first);
    empty   = (count == 2'd0);
    full    = (count == 2'd2);
    pop     = ~empty & bus.i_acc_rdy;
    push    = beat & last;
    do_push = push & (~full | pop);
    overrun = push & full & ~pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      acc <= '0;
      sat <= 1'b0;
    end else if (bus.i_clr) begin
      cnt <= '0;
    end else if (beat) begin
      acc <= nxt_acc;
      sat <= nxt_sat;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // On push+pop while full, wr_ptr equals rd_ptr: the slot being popped is refilled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_acc[0] <= '0;
      mem_acc[1] <= '0;
      mem_sat[0] <= 1'b0;
      mem_sat[1] <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (do_push) begin
        mem_acc[wr_ptr] <= nxt_acc;
        mem_sat[wr_ptr] <= nxt_sat;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_err <= 1'b0;
    end else if (overrun) begin
      ovr_err <= 1'b1;
    end else if (bus.i_err_clr) begin
      ovr_err <= 1'b0;
    end
  end

  assign bus.o_acc     = empty ? '0 : mem_acc[rd_ptr];
  assign bus.o_acc_sat = empty ? 1'b0 : mem_sat[rd_ptr];
  assign bus.o_acc_vld = ~empty;
  assign bus.o_busy    = (cnt != '0);
  assign bus.o_ovr_err = ovr_err;
endmodule
